skid_pipe_register: RTL

- Two-entry valid/ready pipeline register with skid buffer.
- Sits directly downstream of the datapath select multiplexers (forwarding/PC-source muxes) and registers the selected word into the next pipeline stage.
- Breaks the combinational ready path between stages while sustaining one transfer per cycle.

---
 rtl/skid_pipe_register.sv | 118 +++++++++++
 1 files changed

// File: rtl/skid_pipe_register.sv
// skid_pipe_register: two-entry valid/ready pipeline register with skid buffer.
// Ports: i_Clock/i_Reset (async, active-high), upstream i_Valid/o_Ready/i_Data,
// downstream o_Valid/i_Ready/o_Data, occupancy o_Count (0..2).
// Optional macro SKID_FLUSH_EN adds i_Flush, which empties the buffer at a clock edge.
module skid_pipe_register #(
    parameter int WIDTH = 32
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_Data,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Data,
    output logic [1:0]       o_Count
`ifdef SKID_FLUSH_EN
    ,
    input  logic             i_Flush
`endif
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;
    logic             flush;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;

`ifdef SKID_FLUSH_EN
    assign flush = i_Flush;
`else
    assign flush = 1'b0;
`endif

    // Handshake outputs depend on state only, so no combinational
    // path exists from i_Ready to o_Ready.
    assign o_Valid  = (state != EMPTY);
    assign o_Ready  = (state != FULL);
    assign o_Data   = main_q;
    assign in_fire  = i_Valid & o_Ready;
    assign out_fire = o_Valid & i_Ready;

    always_comb begin
        o_Count = 2'd0;
        unique case (state)
            BUSY:    o_Count = 2'd1;
            FULL:    o_Count = 2'd2;
            default: o_Count = 2'd0;
        endcase
    end

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main  = 1'b1;
                        state_next = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // o_Ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        main_from_skid = 1'b1;
                        state_next     = BUSY;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_next;
            if (load_main) begin
                main_q <= i_Data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= i_Data;
            end
        end
    end

endmodule
